// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log-shifter pipeline with runtime rotate/logical/arithmetic modes, left or right.
// Stage k shifts by 2^k when amt bit k is set; valid/ready backpressure collapses bubbles.
module pipelined_barrel_shifter #(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic          up_dir,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);
  logic [SW-1:0] valid_q, valid_d, ready, src_valid;
  logic [N-1:0]  data_q [SW], data_d [SW], src_data [SW], shf_data [SW];
  logic [SW-1:0] amt_q [SW], amt_d [SW], src_amt [SW];
  logic          dir_q [SW], dir_d [SW], src_dir [SW];
  logic [1:0]    mode_q [SW], mode_d [SW], src_mode [SW];

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [N-1:0] d, rot_l, rot_r, sft_l, sft_r, ari_r;
    if (k == 0) begin : g_in
      assign src_valid[k] = up_valid;
      assign src_data[k]  = up_data;
      assign src_amt[k]   = up_amt;
      assign src_dir[k]   = up_dir;
      assign src_mode[k]  = up_mode;
    end else begin : g_prev
      assign src_valid[k] = valid_q[k-1];
      assign src_data[k]  = data_q[k-1];
      assign src_amt[k]   = amt_q[k-1];
      assign src_dir[k]   = dir_q[k-1];
      assign src_mode[k]  = mode_q[k-1];
    end
    assign d     = src_data[k];
    assign rot_l = {d[N-S-1:0], d[N-1:N-S]};
    assign rot_r = {d[S-1:0], d[N-1:S]};
    assign sft_l = d << S;
    assign sft_r = d >> S;
    // The MSB is never disturbed by earlier right shifts, so it is still the operand sign here.
    assign ari_r = {{S{d[N-1]}}, d[N-1:S]};
    assign shf_data[k] = !src_amt[k][k]         ? d :
                         src_mode[k] == 2'b01   ? (src_dir[k] ? sft_r : sft_l) :
                         src_mode[k] == 2'b10   ? (src_dir[k] ? ari_r : sft_l) :
                                                  (src_dir[k] ? rot_r : rot_l);
  end

  always_comb begin
    logic r;
    r = down_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      r          = r | ~valid_q[k];
      ready[k]   = r;
      valid_d[k] = r ? src_valid[k] : valid_q[k];
      data_d[k]  = (r && src_valid[k]) ? shf_data[k] : data_q[k];
      amt_d[k]   = (r && src_valid[k]) ? src_amt[k]  : amt_q[k];
      dir_d[k]   = (r && src_valid[k]) ? src_dir[k]  : dir_q[k];
      mode_d[k]  = (r && src_valid[k]) ? src_mode[k] : mode_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        dir_q[k]  <= 1'b0;
        mode_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign up_ready   = ready[0];
  assign down_valid = valid_q[SW-1];
  assign down_data  = data_q[SW-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench for the N=8 pipelined barrel shifter.
module tb_pipelined_barrel_shifter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       up_valid = 1'b0, up_ready, up_dir = 1'b0;
  logic [7:0] up_data = 8'h00, down_data;
  logic [2:0] up_amt = 3'd0;
  logic [1:0] up_mode = 2'd0;
  logic       down_valid, down_ready = 1'b1;
  int         checks = 0, errors = 0, cyc = 0;
  bit         stream = 1'b0, hold_prev = 1'b0;
  logic [7:0] prev_data;

  typedef struct {logic [7:0] exp; int t; bit lat;} item_t;
  typedef struct {logic [7:0] a; logic [2:0] s; logic d; logic [1:0] m; logic [7:0] e;} vec_t;
  item_t q[$];
  item_t mon_e;
  vec_t vt [16] = '{
    '{8'hB5, 3'd3, 1'b0, 2'd0, 8'hAD}, '{8'hB5, 3'd3, 1'b1, 2'd0, 8'hB6},
    '{8'hB5, 3'd3, 1'b1, 2'd1, 8'h16}, '{8'hB5, 3'd3, 1'b1, 2'd2, 8'hF6},
    '{8'h70, 3'd3, 1'b1, 2'd2, 8'h0E}, '{8'hB5, 3'd3, 1'b0, 2'd1, 8'hA8},
    '{8'hB5, 3'd3, 1'b0, 2'd2, 8'hA8}, '{8'hB5, 3'd3, 1'b1, 2'd3, 8'hB6},
    '{8'hD1, 3'd0, 1'b0, 2'd0, 8'hD1}, '{8'hD1, 3'd0, 1'b1, 2'd1, 8'hD1},
    '{8'hD1, 3'd0, 1'b1, 2'd2, 8'hD1}, '{8'hD1, 3'd0, 1'b0, 2'd3, 8'hD1},
    '{8'h80, 3'd7, 1'b0, 2'd0, 8'h40}, '{8'h80, 3'd7, 1'b1, 2'd2, 8'hFF},
    '{8'h80, 3'd7, 1'b1, 2'd1, 8'h01}, '{8'hD1, 3'd0, 1'b1, 2'd0, 8'hD1}};

  pipelined_barrel_shifter #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_amt(up_amt), .up_dir(up_dir), .up_mode(up_mode),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s,
                                       input logic d, input logic [1:0] m);
    logic [15:0] w;
    logic signed [7:0] sa;
    logic [7:0] r;
    w  = {a, a};
    sa = a;
    if (m == 2'd1) r = d ? (a >> s) : (a << s);
    else if (m == 2'd2) r = d ? 8'(sa >>> s) : (a << s);
    else r = d ? w[7:0] >> 0 : a;
    if (m == 2'd0 || m == 2'd3) begin
      w = d ? ({a, a} >> s) : ({a, a} << s);
      r = d ? w[7:0] : w[15:8];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) hold_prev = 1'b0;
    else begin
      if (hold_prev) check("hold_stable", down_data, prev_data);
      hold_prev = down_valid && !down_ready;
      prev_data = down_data;
      if (stream) check("up_ready_stream", 8'(up_ready), 8'd1);
      if (down_valid && down_ready) begin
        if (q.size() == 0) check("spurious_out", 8'(down_valid), 8'd0);
        else begin
          mon_e = q.pop_front();
          check("data", down_data, mon_e.exp);
          if (mon_e.lat) check("latency", 8'(cyc - mon_e.t), 8'd3);
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [2:0] s, input logic d,
                      input logic [1:0] m, input logic [7:0] e, input bit lat);
    int n = 0;
    up_valid = 1'b1; up_data = a; up_amt = s; up_dir = d; up_mode = m;
    @(negedge clk);
    while (!up_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (up_ready) q.push_back('{e, cyc, lat});
    else check("accept_timeout", 8'd0, 8'd1);
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [7:0] a;
    logic [2:0] s;
    logic d;
    logic [1:0] m;
    a = 8'($urandom); s = 3'($urandom_range(0, 7)); d = 1'($urandom); m = 2'($urandom);
    send(a, s, d, m, model(a, s, d, m), lat);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 8'(q.size()), 8'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_down_valid", 8'(down_valid), 8'd0);
    check("rst_down_data", down_data, 8'h00);
    check("rst_up_ready", 8'(up_ready), 8'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stream = 1'b1;
    foreach (vt[i]) send(vt[i].a, vt[i].s, vt[i].d, vt[i].m, vt[i].e, 1'b1);
    for (int i = 0; i < 8; i++)
      for (int d = 0; d < 2; d++)
        send(8'(1 << i), 3'd3, 1'(d), 2'd0, model(8'(1 << i), 3'd3, 1'(d), 2'd0), 1'b1);
    repeat (20) send_rand(1'b1);
    stream = 1'b0;
    drain();
    down_ready = 1'b0;
    repeat (3) send_rand(1'b0);
    fork
      send(8'h3C, 3'd2, 1'b1, 2'd0, 8'h0F, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_up_ready", 8'(up_ready), 8'd0);
          check("full_down_data", down_data, q[0].exp);
        end
        @(posedge clk); #1 down_ready = 1'b1;
        @(negedge clk);
        check("accept_and_drain", {6'd0, up_ready, down_valid}, 8'd3);
      end
    join
    send(8'h81, 3'd1, 1'b0, 2'd1, 8'h02, 1'b0);
    drain();
    down_ready = 1'b0;
    send(8'h5A, 3'd4, 1'b0, 2'd0, 8'hA5, 1'b0);
    send(8'hC3, 3'd1, 1'b1, 2'd2, 8'hE1, 1'b0);
    @(posedge clk); #3;
    check("pre_reset_valid", 8'(down_valid), 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_down_valid", 8'(down_valid), 8'd0);
    check("mid_rst_down_data", down_data, 8'h00);
    check("mid_rst_up_ready", 8'(up_ready), 8'd1);
    q.delete();
    @(posedge clk); #2 rst_n = 1'b1; down_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 8'(down_valid), 8'd0);
    end
    @(posedge clk); #1;
    send(8'h96, 3'd5, 1'b1, 2'd1, 8'h04, 1'b1);
    drain();
    check("queue_empty", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
